// File: rtl/mdu_pkg.sv
// mdu_pkg: shared encodings for the multiply/divide unit.
// Op codes, FSM states and default latency constants.
package mdu_pkg;

    localparam logic [2:0] MDU_MULT  = 3'd0;
    localparam logic [2:0] MDU_MULTU = 3'd1;
    localparam logic [2:0] MDU_DIV   = 3'd2;
    localparam logic [2:0] MDU_DIVU  = 3'd3;
    localparam logic [2:0] MDU_MTHI  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MADD  = 3'd6;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int DEF_WIDTH       = 32;
    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

endpackage

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit with HI/LO registers.
// Optional MADD accumulate op enabled by defining MDU_MADD_EN.
//
// Ports:
//   clk     - clock, all state on rising edge
//   reset   - synchronous active-high reset
//   start   - one-cycle issue strobe (ignored while busy)
//   op      - 0 MULT 1 MULTU 2 DIV 3 DIVU 4 MTHI 5 MTLO 6 MADD
//   rs_val  - operand A (dividend / multiplicand / mt source)
//   rt_val  - operand B (divisor / multiplier)
//   busy    - high while an operation is in flight
//   hi, lo  - result registers
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES)
                        ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    state_t           state, state_n;
    logic [CW-1:0]    cnt, cnt_n;
    logic [2:0]       op_q, op_n;
    logic [WIDTH-1:0] a_q, a_n;
    logic [WIDTH-1:0] b_q, b_n;
    logic [WIDTH-1:0] hi_n, lo_n;

    logic             is_mul, is_div, is_mthi, is_mtlo;
    logic [2*WIDTH-1:0] res;

    assign busy = (state == ST_RUN);

    assign is_div  = (op == MDU_DIV) || (op == MDU_DIVU);
    assign is_mthi = (op == MDU_MTHI);
    assign is_mtlo = (op == MDU_MTLO);
`ifdef MDU_MADD_EN
    assign is_mul  = (op == MDU_MULT) || (op == MDU_MULTU)
                  || (op == MDU_MADD);
`else
    assign is_mul  = (op == MDU_MULT) || (op == MDU_MULTU);
`endif

    // Multiply: sign- or zero-extend to 2W, keep low 2W bits.
    logic [2*WIDTH-1:0] prod_s, prod_u;
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q}
                  * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Divide: magnitude divide, then fix signs. MIN / -1 falls
    // out naturally as quotient MIN, remainder 0.
    logic             b_zero, a_neg, b_neg;
    logic [WIDTH-1:0] b_safe, a_mag, b_mag;
    logic [WIDTH-1:0] qu, ru, qm, rm, qs, rs;

    assign b_zero = (b_q == '0);
    assign b_safe = b_zero ? WIDTH'(1) : b_q;
    assign a_neg  = a_q[WIDTH-1];
    assign b_neg  = b_q[WIDTH-1];
    assign a_mag  = a_neg ? -a_q : a_q;
    assign b_mag  = b_zero ? WIDTH'(1)
                  : (b_neg ? -b_q : b_q);
    assign qu     = a_q / b_safe;
    assign ru     = a_q % b_safe;
    assign qm     = a_mag / b_mag;
    assign rm     = a_mag % b_mag;
    assign qs     = (a_neg ^ b_neg) ? -qm : qm;
    assign rs     = a_neg ? -rm : rm;

    always_comb begin
        res = {hi, lo};
        case (op_q)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV:   res = b_zero ? {a_q, {WIDTH{1'b1}}}
                                    : {rs, qs};
            MDU_DIVU:  res = b_zero ? {a_q, {WIDTH{1'b1}}}
                                    : {ru, qu};
`ifdef MDU_MADD_EN
            // Accumulates onto hi/lo as they stand at completion.
            MDU_MADD:  res = {hi, lo} + prod_s;
`endif
            default:   res = {hi, lo};
        endcase
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        op_n    = op_q;
        a_n     = a_q;
        b_n     = b_q;
        hi_n    = hi;
        lo_n    = lo;
        if (state == ST_IDLE) begin
            if (start) begin
                unique case (1'b1)
                    is_mul: begin
                        state_n = ST_RUN;
                        cnt_n   = CW'(MULT_CYCLES);
                        op_n    = op;
                        a_n     = rs_val;
                        b_n     = rt_val;
                    end
                    is_div: begin
                        state_n = ST_RUN;
                        cnt_n   = CW'(DIV_CYCLES);
                        op_n    = op;
                        a_n     = rs_val;
                        b_n     = rt_val;
                    end
                    is_mthi: hi_n = rs_val;
                    is_mtlo: lo_n = rs_val;
                    default: ;
                endcase
            end
        end else begin
            cnt_n = cnt - CW'(1);
            if (cnt == CW'(1)) begin
                state_n      = ST_IDLE;
                {hi_n, lo_n} = res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            hi    <= '0;
            lo    <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
            a_q   <= a_n;
            b_q   <= b_n;
            hi    <= hi_n;
            lo    <= lo_n;
        end
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Parametrised multiply/divide unit with HI/LO registers for the pipelined CPU generation.
- Sits in the EX stage beside the ALU; executes mult/multu/div/divu/mthi/mtlo.
- Models multi-cycle latency with a busy flag; the hazard unit uses busy to stall mfhi/mflo and further MDU instructions.
- Generalises the fixed single-cycle datapath in width and latency, and adds a start/busy handshake.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (and madd); must be ≥1.
- DIV_CYCLES, 10, busy cycles for div/divu; must be ≥1.

Ports:
- clk  input  1  system clock. One clock domain; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  issue strobe, valid for one cycle.
- op  input  3  operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD (feature only), 7 reserved.
- rs_val  input  WIDTH  operand A (dividend / multiplicand / mt source).
- rt_val  input  WIDTH  operand B (divisor / multiplier).
- busy  output  1  registered; high while an operation is in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset:
  - busy=0, hi=0, lo=0; counter=0; latched operands/op cleared.
  - Reset mid-operation aborts it; no result is ever written.
- States:
  - IDLE: busy=0.
  - RUN: busy=1, down-counter active.
- IDLE -> RUN: start=1 with op in {0,1,2,3,(6)}.
  - Operands and op are latched at that edge.
  - Counter loads MULT_CYCLES or DIV_CYCLES as appropriate.
- Timing for start sampled at edge t:
  - busy=1 for cycles t+1 … t+N.
  - hi/lo are written at edge t+N, simultaneously with busy falling.
  - Back-to-back: a new start is accepted on the first cycle busy=0 after completion.
- MTHI/MTLO in IDLE:
  - start with op 4/5 writes hi or lo with rs_val at the same edge; busy stays 0.
  - The other register is untouched.
- start while busy=1: ignored entirely; operands, op, counter, hi and lo are unaffected. The CPU must stall; the bench checks that the ignore holds.
- op 7, or op 6 without the feature: no-op, no state change.
- Arithmetic:
  - MULT: signed 2·WIDTH product; hi = upper WIDTH bits, lo = lower.
  - MULTU: as MULT, unsigned.
  - DIV: signed; quotient truncates toward zero -> lo; remainder takes the dividend's sign -> hi.
  - DIVU: unsigned; lo = quotient, hi = remainder.
- Divisor zero (DIV or DIVU): lo = all ones, hi = rs_val.
- Signed overflow (DIV of MIN by -1): lo = MIN, hi = 0.
- Results are computed from the latched operands, never from the live ports.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined:
  - op 6 (MADD) is legal.
  - {hi,lo} <= {hi,lo} + signed(rs_val × rt_val), modulo 2^(2·WIDTH).
  - MULT_CYCLES latency.
  - Accumulates onto the hi/lo value present at completion time.
- Undefined: op 6 is a no-op; no accumulator logic is synthesised.

Decomposition:
- Package mdu_pkg:
  - op encoding constants (MDU_MULT … MDU_MADD);
  - state encoding (ST_IDLE, ST_RUN);
  - default latency constants.
- No sub-module needed. Arithmetic is behavioural and latency is a single inline down-counter; the whole block is one module.

Test Plan:
1. MULT with rs=0xFFFFFFFE (-2), rt=3 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
2. DIVU with rs=100, rt=7 -> busy 10 cycles; lo=14, hi=2. DIV with rs=-7, rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
3. DIV with rs=5, rt=0 -> lo=0xFFFFFFFF, hi=5. DIV with rs=0x80000000, rt=0xFFFFFFFF -> lo=0x80000000, hi=0.
4. MTHI 0x1234 in IDLE -> hi=0x1234 next edge, busy stays 0, lo unchanged. MULTU issued and a second start during busy -> second start ignored; result matches the first operands.
5. MULT started, reset asserted at cycle 3 of busy -> next edge busy=0, hi=lo=0; no write appears afterwards.
6. MDU_MADD_EN defined, hi=0, lo=10, MADD with rs=-1, rt=4 -> after 5 cycles hi=0, lo=6. Without the macro, op 6 leaves hi/lo/busy unchanged.
